// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM states,
// default geometry and fetch-address field extraction.
package icache_pkg;

  localparam int LINES_DEF = 16;
  localparam int WORDS_DEF = 4;
  localparam int OFF_W     = $clog2(WORDS_DEF);
  localparam int IDX_W     = $clog2(LINES_DEF);
  localparam int TAG_W     = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_e;

  // Field extractors take the widths as arguments so they also serve
  // non-default geometries; callers size-cast the result.
  function automatic logic [31:0] pc_word(input logic [31:0] pc, input int off_w);
    return (pc >> 2) & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int off_w,
                                           input int idx_w);
    return (pc >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int off_w,
                                         input int idx_w);
    return pc >> (2 + off_w + idx_w);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: one combinational read
// port, one word-write port for refill, and a line commit that sets valid.
module icache_array
  import icache_pkg::*;
#(
  parameter int LINES    = LINES_DEF,
  parameter int WORDS    = WORDS_DEF,
  parameter int OFF_BITS = OFF_W,
  parameter int IDX_BITS = IDX_W,
  parameter int TAG_BITS = TAG_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  input  logic [OFF_BITS-1:0] rd_word,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [31:0]         rd_data,
  input  logic [IDX_BITS-1:0] fill_idx,
  input  logic                wr_en,
  input  logic [OFF_BITS-1:0] wr_word,
  input  logic [31:0]         wr_data,
  input  logic                commit_en,
  input  logic [TAG_BITS-1:0] commit_tag,
  input  logic                inval_en,
  input  logic [IDX_BITS-1:0] inval_idx
);

  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    valid_d;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES][WORDS];

  always_comb begin
    valid_d = valid_q;
    if (inval_en) valid_d[inval_idx] = 1'b0;
    if (commit_en) valid_d[fill_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tags and data are never reset; an invalid line's contents are don't-care.
  always_ff @(posedge clk) begin
    if (commit_en) tag_q[fill_idx] <= commit_tag;
    if (wr_en)     data_q[fill_idx][wr_word] <= wr_data;
  end

  always_comb begin
    rd_valid = valid_q[rd_idx];
    rd_tag   = tag_q[rd_idx];
    rd_data  = data_q[rd_idx][rd_word];
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: zero-latency hit path, stall
// on miss, in-order line refill over a word req/ready memory handshake.
module icache_direct
  import icache_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int WORD_BITS  = $clog2(WORDS);
  localparam int INDEX_BITS = $clog2(LINES);
  localparam int TAG_BITS   = 30 - WORD_BITS - INDEX_BITS;

  logic [WORD_BITS-1:0]  pc_w;
  logic [INDEX_BITS-1:0] pc_i;
  logic [TAG_BITS-1:0]   pc_t;

  state_e                state_q, state_d;
  logic [WORD_BITS-1:0]  cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;

  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [31:0]           rd_data;
  logic                  hit;
  logic                  last_word;
  logic [WORD_BITS-1:0]  cnt_nxt;
  logic                  wr_en;
  logic                  commit_en;
  logic                  inval_en;

  always_comb begin
    pc_w = WORD_BITS'(pc_word(pc, WORD_BITS));
    pc_i = INDEX_BITS'(pc_index(pc, WORD_BITS, INDEX_BITS));
    pc_t = TAG_BITS'(pc_tag(pc, WORD_BITS, INDEX_BITS));
  end

  icache_array #(
    .LINES    (LINES),
    .WORDS    (WORDS),
    .OFF_BITS (WORD_BITS),
    .IDX_BITS (INDEX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (pc_i),
    .rd_word    (pc_w),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .fill_idx   (miss_idx_q),
    .wr_en      (wr_en),
    .wr_word    (cnt_q),
    .wr_data    (mem_rdata),
    .commit_en  (commit_en),
    .commit_tag (miss_tag_q),
    .inval_en   (inval_en),
    .inval_idx  (pc_i)
  );

  // Hits are only honoured in IDLE; FILL and DONE always stall.
  always_comb begin
    hit   = (state_q == IDLE) && rd_valid && (rd_tag == pc_t);
    stall = !hit;
    instr = hit ? rd_data : 32'h0;
  end

  always_comb begin
    last_word = (cnt_q == WORD_BITS'(WORDS - 1));
    cnt_nxt   = cnt_q + WORD_BITS'(1);
    wr_en     = (state_q == FILL) && mem_ready;
    commit_en = wr_en && last_word;
    inval_en  = (state_q == IDLE) && !hit;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    unique case (state_q)
      IDLE: begin
        if (!hit) begin
          miss_tag_d = pc_t;
          miss_idx_d = pc_i;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = {pc_t, pc_i, {WORD_BITS{1'b0}}, 2'b00};
          state_d    = FILL;
        end
      end
      FILL: begin
        if (mem_ready) begin
          cnt_d = cnt_nxt;
          if (last_word) begin
            mem_req_d = 1'b0;
            state_d   = DONE;
          end else begin
            mem_addr_d = {miss_tag_q, miss_idx_q, cnt_nxt, 2'b00};
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // The miss address is only meaningful while a fill is in progress.
  always_ff @(posedge clk) begin
    miss_tag_q <= miss_tag_d;
    miss_idx_q <= miss_idx_d;
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: directed fetches push expected
// instructions, stall counts and memory addresses; a monitor pops and compares.
module tb_icache_direct;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_instr_q [$];
  int          exp_stall_q [$];
  logic        fetch_active = 1'b0;
  int          stall_cnt = 0;
  int          hs_cnt = 0;

  int          lat = 2;
  logic        spurious = 1'b0;
  int          wait_cnt = 0;

  icache_direct dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .instr     (instr),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: word at byte address a holds 0x1000 + a/4; ready after lat cycles.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (wait_cnt >= lat - 1) begin
          mem_ready = 1'b1;
          mem_rdata = 32'h1000 + (mem_addr >> 2);
          wait_cnt  = 0;
        end else begin
          mem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ready = spurious;
        mem_rdata = 32'hDEADBEEF;
        wait_cnt  = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && mem_ready) begin
        hs_cnt++;
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_mem_req", mem_addr, 32'hFFFFFFFF);
        end else begin
          chk("mem_addr", mem_addr, exp_addr_q.pop_front());
        end
      end
      if (fetch_active) begin
        if (stall) begin
          stall_cnt++;
        end else begin
          chk("instr", instr, exp_instr_q.pop_front());
          chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall_q.pop_front()));
          chk("mem_req_on_hit", {31'b0, mem_req}, 32'h0);
          fetch_active = 1'b0;
        end
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #2;
  endtask

  task automatic push_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(base + 32'(4 * i));
  endtask

  // Called at posedge+2; returns at posedge+2 once the instruction was delivered.
  task automatic fetch(input logic [31:0] a, input logic [31:0] e, input int st);
    pc = a;
    exp_instr_q.push_back(e);
    exp_stall_q.push_back(st);
    stall_cnt    = 0;
    fetch_active = 1'b1;
    for (int i = 0; i < 200 && fetch_active; i++) @(posedge clk);
    if (fetch_active) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: pc %h still stalled, expected instr %h", a, e);
      fetch_active = 1'b0;
      void'(exp_instr_q.pop_front());
      void'(exp_stall_q.pop_front());
    end
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int hs0;
    reset = 1'b1;
    pc    = 32'h0;
    #12;
    chk("rst_stall", {31'b0, stall}, 32'h1);
    chk("rst_instr", instr, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);

    // Cold miss, 2-cycle memory: 1 + 4*2 + 1 stall cycles.
    align();
    reset = 1'b0;
    lat   = 2;
    push_line(32'h0);
    fetch(32'h0, 32'h1000, 10);

    fetch(32'h8, 32'h1002, 0);
    fetch(32'hC, 32'h1003, 0);

    // Conflict on index 0, then refetch of the evicted line.
    push_line(32'h100);
    fetch(32'h100, 32'h1040, 10);
    fetch(32'h10C, 32'h1043, 0);
    push_line(32'h0);
    fetch(32'h0, 32'h1000, 10);

    // Zero-latency memory.
    lat = 1;
    push_line(32'h40);
    fetch(32'h40, 32'h1010, 6);
    fetch(32'h44, 32'h1011, 0);

    // Reset in the middle of a fill of line 0x0.
    reset = 1'b1;
    align();
    reset = 1'b0;
    lat   = 2;
    pc    = 32'h0;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    hs0 = hs_cnt;
    for (int i = 0; i < 50 && (hs_cnt - hs0) < 2; i++) @(posedge clk);
    if ((hs_cnt - hs0) < 2) begin
      checks++;
      errors++;
      $display("FAIL midfill_timeout: handshakes %0d expected 2", hs_cnt - hs0);
    end
    #2;
    chk("midfill_mem_req", {31'b0, mem_req}, 32'h1);
    chk("midfill_mem_addr", mem_addr, 32'h8);
    #1;
    reset = 1'b1;
    #1;
    chk("midfill_rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("midfill_rst_stall", {31'b0, stall}, 32'h1);
    chk("midfill_rst_instr", instr, 32'h0);
    @(posedge clk);
    align();
    reset = 1'b0;
    push_line(32'h0);
    fetch(32'h0, 32'h1000, 10);

    // Spurious ready while hitting: no write, no state change.
    spurious = 1'b1;
    fetch(32'h4, 32'h1001, 0);
    fetch(32'h4, 32'h1001, 0);
    fetch(32'h4, 32'h1001, 0);
    spurious = 1'b0;
    align();
    fetch(32'h4, 32'h1001, 0);
    fetch(32'h8, 32'h1002, 0);
    fetch(32'hC, 32'h1003, 0);

    chk("addr_queue_drained", 32'(exp_addr_q.size()), 32'h0);
    chk("instr_queue_drained", 32'(exp_instr_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache that sits immediately upstream of the pipelined datapath's fetch port.
- Takes the datapath's fetch address (pc) and returns the instruction word (instr).
- On a miss, raises stall, which is ORed into the datapath's StallF/StallD, and refills one line from main memory over a simple req/ready word handshake.

Parameters:
- LINES, 16, number of cache lines (power of 2, ≥2)
- WORDS, 4, 32-bit words per line (power of 2, ≥2)
- Derived, fixed: OFF_W=log2(WORDS), IDX_W=log2(LINES), TAG_W=30-OFF_W-IDX_W

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pc  in  32  fetch byte address from datapath
- instr  out  32  instruction for pc; valid when stall=0
- stall  out  1  1 = instr not valid; datapath must hold pc and IF/ID
- mem_req  out  1  word read request to main memory
- mem_addr  out  32  word-aligned request address; stable while mem_req=1
- mem_ready  in  1  one-cycle pulse: mem_rdata valid, current request done
- mem_rdata  in  32  read data from memory

Behaviour:
- Address split: pc[1:0] ignored; word=pc[2+OFF_W-1:2]; index=next IDX_W bits; tag=pc[31:32-TAG_W].
- Storage: per line a valid bit, a TAG_W tag and WORDS data words. Reset asynchronously clears all valid bits only; data and tags are don't-care.
- Hit (state IDLE, valid[index] and tag match) is combinational, zero-latency: stall=0, instr=data[index][word] in the same cycle.
- Miss in IDLE:
  - stall=1 and instr=32'h0 (nop) combinationally.
  - Next edge: latch tag/index into miss_addr, clear valid[index], cnt=0, go to FILL.
- FILL:
  - mem_req=1, mem_addr={miss_tag, miss_index, cnt, 2'b00}.
  - On mem_ready: write mem_rdata to data[miss_index][cnt] and increment cnt.
  - On mem_ready with cnt==WORDS-1: write tag, set valid, go to DONE.
  - Words are always fetched in order 0..WORDS-1 (no critical-word-first).
  - mem_ready may arrive in the first cycle mem_req is high.
- DONE: one cycle, stall=1, mem_req=0, then return to IDLE, where the lookup replays against the current pc.
- Miss penalty: 1 (IDLE detect) + sum of per-word memory latencies + 1 (DONE) cycles of stall.
- stall=1 in FILL and DONE regardless of pc. The fill always completes for the latched address even if pc changes.
- mem_ready while mem_req=0 is ignored; no state or array change.
- Reset mid-fill: immediately state=IDLE, mem_req=0, cnt=0, all valid=0. Partial line data is discarded.
- Reset values: state IDLE, mem_req=0, mem_addr=0, cnt=0. stall and instr then follow the combinational miss path (stall=1, instr=0 because all lines are invalid).
- mem_req deasserts combinationally when leaving FILL. mem_addr holds its last value whenever mem_req=0.
- No writes from the core: self-modifying code is unsupported.

Decomposition:
- Shared package icache_pkg:
  - state enum {IDLE, FILL, DONE}
  - localparams OFF_W, IDX_W, TAG_W and address-field extraction functions
- One sub-module, icache_array:
  - valid/tag/data storage, one combinational read port, one synchronous word-write port
  - line-commit input that writes the tag and sets valid
  - async valid clear on reset
- The top level holds the FSM, counter and memory interface.

Test Plan:
- Cold miss: after reset, pc=0x0; memory returns word i = 0x1000+i after 2-cycle latency. Required: mem_addr 0x0, 0x4, 0x8, 0xC; stall high for 1+4×2+1 = 10 cycles; then instr=0x1000, stall=0.
- Line hit: after the cold fill, pc=0x8 then 0xC. Required: stall=0 each cycle, instr=0x1002 then 0x1003, mem_req stays 0.
- Conflict eviction (LINES=16, WORDS=4): fill 0x0, then pc=0x100 (same index 0). Required: miss, refill from 0x100..0x10C. Then pc=0x0 misses again and refetches from 0x0.
- Zero-latency memory: mem_ready high in every cycle mem_req is high, pc=0x40. Required: 4 consecutive words fetched in 4 FILL cycles, stall for 6 cycles total.
- Reset mid-fill: assert reset after 2 of 4 words of line 0x0. Required: mem_req drops in the same cycle; after release, pc=0x0 misses again and fetches from 0x0.
- Spurious ready: pulse mem_ready in IDLE during a hit on 0x4. Required: instr unchanged, no array write, no state change.
